// File: rtl/fuzz_harness_pkg.sv
// fuzz_harness_pkg: shared polynomials, harness state encoding and fold/LFSR helpers.
package fuzz_harness_pkg;
  localparam logic [63:0] LFSR_POLY = 64'hD800000000000000;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_APPLY, S_DONE} state_t;

  // Callers zero-extend their output bus to 256 bits, which pads the last word.
  function automatic logic [31:0] fold32(input logic [255:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f ^= v[i*32 +: 32];
    return f;
  endfunction

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 64'h0);
  endfunction
endpackage

// File: rtl/fuzz_misr32.sv
// fuzz_misr32: 32-bit MISR over the word-folded synthesized-netlist output.
module fuzz_misr32
  import fuzz_harness_pkg::*;
#(
  parameter int OUT_W = 127
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [OUT_W-1:0] i_y,
  output logic [31:0]      o_sig
);
  logic [31:0] r_sig;
  logic [31:0] w_fold;

  assign w_fold = fold32(256'(i_y));
  assign o_sig  = r_sig;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sig <= '0;
    else if (i_clr) r_sig <= '0;
    else if (i_en) r_sig <= {r_sig[30:0], 1'b0} ^ (r_sig[31] ? MISR_POLY : 32'h0) ^ w_fold;
endmodule

// File: rtl/fuzz_equiv_harness.sv
// fuzz_equiv_harness: drives LFSR vectors into two netlists, compares them once per
// hold window and keeps mismatch/first-fail/fail-count results plus a MISR signature.
module fuzz_equiv_harness
  import fuzz_harness_pkg::*;
#(
  parameter int          IN_W    = 52,
  parameter int          OUT_W   = 127,
  parameter int          NUM_VEC = 21,
  parameter int          HOLD    = 1,
  parameter logic [63:0] SEED    = 64'h1,
  parameter int          COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [IN_W-1:0]    stim,
  input  logic [OUT_W-1:0]   y_ref,
  input  logic [OUT_W-1:0]   y_dut,
  output logic               busy,
  output logic               done,
  output logic [7:0]         vec_idx,
  output logic               mismatch,
  output logic [7:0]         first_fail_idx,
  output logic [COUNT_W-1:0] fail_count,
  output logic [31:0]        signature
);
  localparam logic [63:0]    SEED_EFF  = (SEED == 64'h0) ? 64'h1 : SEED;
  localparam int             HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);
  localparam logic [7:0]     LAST_VEC  = 8'(NUM_VEC);

  state_t             r_state, w_next;
  logic [63:0]        r_lfsr, w_lfsr_nxt;
  logic [IN_W-1:0]    r_stim;
  logic [HW-1:0]      r_hold;
  logic [7:0]         r_vec, r_ffi;
  logic               r_mis;
  logic [COUNT_W-1:0] r_fc;
  logic               w_busy, w_last, w_start, w_sample, w_end, w_neq;

  assign w_busy     = r_state inside {S_ZERO, S_APPLY};
  assign w_last     = r_hold == HOLD_LAST;
  assign w_start    = !w_busy && start && !abort;
  // An aborted window is not compared; results keep their pre-abort values.
  assign w_sample   = w_busy && w_last && !abort;
  assign w_end      = r_vec == LAST_VEC;
  assign w_neq      = y_ref != y_dut;
  assign w_lfsr_nxt = lfsr_next(r_lfsr);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    w_next = abort ? S_IDLE :
             w_start ? S_ZERO :
             (w_sample && w_end) ? S_DONE :
             (w_sample && r_state == S_ZERO) ? S_APPLY : r_state;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || w_start) begin
      r_lfsr <= SEED_EFF;
      r_stim <= '0;
      r_hold <= '0;
      r_vec  <= '0;
      r_mis  <= 1'b0;
      r_ffi  <= '0;
      r_fc   <= '0;
    end else if (w_busy && abort) begin
      r_stim <= '0;
      r_hold <= '0;
    end else if (w_busy) begin
      r_hold <= w_last ? '0 : r_hold + 1'b1;
      if (w_last && w_neq) begin
        r_mis <= 1'b1;
        if (!r_mis) r_ffi <= r_vec;
        if (~&r_fc) r_fc <= r_fc + 1'b1;
      end
      // Vector 1 is the seed itself; later vectors step the LFSR once each.
      if (w_last && !w_end) begin
        r_vec  <= r_vec + 1'b1;
        r_stim <= (r_state == S_ZERO) ? r_lfsr[IN_W-1:0] : w_lfsr_nxt[IN_W-1:0];
        if (r_state == S_APPLY) r_lfsr <= w_lfsr_nxt;
      end
    end

  fuzz_misr32 #(.OUT_W(OUT_W)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start),
    .i_en  (w_sample),
    .i_y   (y_dut),
    .o_sig (signature)
  );

  assign stim           = r_stim;
  assign busy           = w_busy;
  assign done           = r_state == S_DONE;
  assign vec_idx        = r_vec;
  assign mismatch       = r_mis;
  assign first_fail_idx = r_ffi;
  assign fail_count     = r_fc;
endmodule

// File: tb/tb_fuzz_equiv_harness.sv
// tb_fuzz_equiv_harness: table-driven runs on a short 64-bit harness plus randomized
// runs on a hold-3, 2-bit-counter harness checked against a behavioural model.
module tb_fuzz_equiv_harness;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 0, a_abort = 0;
  logic [63:0] a_stim;
  logic [31:0] a_yr = '0, a_yd = '0, a_sig;
  logic        a_busy, a_done, a_mis;
  logic [7:0]  a_vec, a_ffi, a_fc;

  logic         b_start = 0, b_abort = 0;
  logic [51:0]  b_stim;
  logic [126:0] b_yr = '0, b_yd = '0;
  logic         b_busy, b_done, b_mis;
  logic [7:0]   b_vec, b_ffi;
  logic [1:0]   b_fc;
  logic [31:0]  b_sig;

  fuzz_equiv_harness #(.IN_W(64), .OUT_W(32), .NUM_VEC(3), .HOLD(1), .SEED(64'h1), .COUNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .stim(a_stim),
    .y_ref(a_yr), .y_dut(a_yd), .busy(a_busy), .done(a_done), .vec_idx(a_vec),
    .mismatch(a_mis), .first_fail_idx(a_ffi), .fail_count(a_fc), .signature(a_sig));

  fuzz_equiv_harness #(.IN_W(52), .OUT_W(127), .NUM_VEC(5), .HOLD(3), .SEED(64'h0), .COUNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .stim(b_stim),
    .y_ref(b_yr), .y_dut(b_yd), .busy(b_busy), .done(b_done), .vec_idx(b_vec),
    .mismatch(b_mis), .first_fail_idx(b_ffi), .fail_count(b_fc), .signature(b_sig));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800000000000000 : 64'h0);
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [255:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f ^= y[i*32 +: 32];
    return {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [126:0] rnd127();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[126:0];
  endfunction

  typedef struct {
    logic [3:0][31:0] yr;
    logic [3:0][31:0] yd;
    logic             mis;
    logic [7:0]       ffi;
    logic [7:0]       fc;
    logic [31:0]      sig;
  } vec_t;

  vec_t tbl[4];
  logic [3:0][63:0] exp_stim;

  task automatic run_a(input int r);
    a_start = 1; @(negedge clk); a_start = 0;
    for (int k = 0; k < 4; k++) begin
      chk("a_stim", a_stim, exp_stim[k]);
      chk("a_vec", a_vec, k);
      chk("a_busy", a_busy, 1);
      chk("a_done_run", a_done, 0);
      a_yr = tbl[r].yr[k];
      a_yd = tbl[r].yd[k];
      @(negedge clk);
    end
    chk("a_done", a_done, 1);
    chk("a_busy_done", a_busy, 0);
    chk("a_stim_hold", a_stim, exp_stim[3]);
    chk("a_mis", a_mis, tbl[r].mis);
    chk("a_ffi", a_ffi, tbl[r].ffi);
    chk("a_fc", a_fc, tbl[r].fc);
    chk("a_sig", a_sig, tbl[r].sig);
  endtask

  task automatic run_b(input int mode);
    logic [63:0]  s;
    logic [51:0]  es;
    logic [126:0] yr, yd;
    logic         em;
    logic [7:0]   effi;
    logic [1:0]   efc;
    logic [31:0]  esig;
    s = 64'h1; es = '0; em = 0; effi = 0; efc = 0; esig = 0;
    b_start = 1; @(negedge clk); b_start = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) es = s[51:0];
      else if (k > 1) begin s = lfsr_step(s); es = s[51:0]; end
      for (int h = 0; h < 3; h++) begin
        chk("b_stim", b_stim, es);
        chk("b_vec", b_vec, k);
        chk("b_busy", b_busy, 1);
        yr = rnd127();
        if (mode == 1) yd = ~yr;
        else if (h < 2) yd = (mode == 0) ? ~yr : rnd127();
        else if (mode == 0) yd = yr;
        else yd = $urandom_range(0, 1) ? yr : yr ^ (127'(1) << $urandom_range(0, 126));
        if (h == 2) begin
          if (yd != yr) begin
            if (!em) effi = 8'(k);
            em = 1;
            if (efc != 2'd3) efc++;
          end
          esig = misr_step(esig, 256'(yd));
        end
        b_yr = yr; b_yd = yd;
        @(negedge clk);
      end
    end
    chk("b_done", b_done, 1);
    chk("b_busy_done", b_busy, 0);
    chk("b_stim_hold", b_stim, es);
    chk("b_mis", b_mis, em);
    chk("b_ffi", b_ffi, effi);
    chk("b_fc", b_fc, efc);
    chk("b_sig", b_sig, esig);
  endtask

  initial begin
    exp_stim = {64'h6C00000000000000, 64'hD800000000000000, 64'h1, 64'h0};
    tbl[0] = '{yr: '0, yd: '0, mis: 0, ffi: 0, fc: 0, sig: 32'h0};
    tbl[1] = '{yr: {4{32'h1}}, yd: {4{32'h1}}, mis: 0, ffi: 0, fc: 0, sig: 32'hF};
    tbl[2] = '{yr: {4{32'h1}}, yd: {32'h1, 32'h0, 32'h1, 32'h1}, mis: 1, ffi: 2, fc: 1, sig: 32'hD};
    tbl[3] = '{yr: '0, yd: {4{32'hFFFFFFFF}}, mis: 1, ffi: 0, fc: 4, sig: 32'h17C56B6E};

    repeat (2) @(negedge clk);
    chk("rst_stim", a_stim, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_sig", a_sig, 0);
    rst_n = 1;
    @(negedge clk);

    for (int r = 0; r < 4; r++) run_a(r);

    a_yr = '0; a_yd = '1;
    a_start = 1; @(negedge clk); a_start = 0;
    repeat (2) @(negedge clk);
    chk("mid_vec", a_vec, 2);
    rst_n = 0;
    #1;
    chk("arst_stim", a_stim, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_done", a_done, 0);
    chk("arst_vec", a_vec, 0);
    chk("arst_mis", a_mis, 0);
    chk("arst_ffi", a_ffi, 0);
    chk("arst_fc", a_fc, 0);
    chk("arst_sig", a_sig, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    run_a(0);

    a_yr = '0; a_yd = 32'h1;
    a_start = 1; @(negedge clk); a_start = 0;
    @(negedge clk);
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    chk("busy_start_vec", a_vec, 2);
    chk("busy_start_stim", a_stim, 64'hD800000000000000);
    a_abort = 1;
    @(negedge clk);
    a_abort = 0;
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    chk("abort_stim", a_stim, 0);
    chk("abort_mis", a_mis, 1);
    @(negedge clk);
    chk("abort_idle_done", a_done, 0);
    a_start = 1; a_abort = 1;
    @(negedge clk);
    a_start = 0; a_abort = 0;
    chk("abort_wins", a_busy, 0);

    run_b(0);
    run_b(1);
    for (int i = 0; i < 4; i++) run_b(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fuzz_equiv_harness.md
Name: fuzz_equiv_harness

Overview:
Synthesizable stimulus/compare engine for fuzz-equivalence runs. It replaces a fixed list of hand-pasted stimulus constants with parametrised LFSR-generated vectors, and drives one shared stimulus bus into a reference netlist and a synthesized netlist. It compares the two outputs once per vector, then reports a mismatch flag, the first failing index, a saturating fail count and a 32-bit MISR signature of the synthesized output. It sits above the two top instances in the simulation and FPGA-emulation harness.

Parameters:
IN_W, 52, stimulus width (1..64); the concatenated DUT input bus.
OUT_W, 127, DUT output width (1..256).
NUM_VEC, 21, number of random vectors applied after the zero vector.
HOLD, 1, clock cycles each vector is held (>=1).
SEED, 64'h1, initial LFSR state; 0 is replaced by 1.
COUNT_W, 8, fail_count width.

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin a run; sampled only in IDLE.
abort  in  1  return to IDLE next cycle; done not set.
stim  out  IN_W  shared stimulus to both DUTs.
y_ref  in  OUT_W  reference netlist output.
y_dut  in  OUT_W  synthesized netlist output.
busy  out  1  high in ZERO/APPLY.
done  out  1  high in DONE until next start.
vec_idx  out  8  index of the vector currently applied (0 = zero vector).
mismatch  out  1  sticky: any compare failed this run.
first_fail_idx  out  8  vec_idx of the first failure; 0 if none.
fail_count  out  COUNT_W  saturating failure count.
signature  out  32  MISR over y_dut.

Behaviour:
- Reset and async assert: stim=0, busy=0, done=0, vec_idx=0, mismatch=0, first_fail_idx=0, fail_count=0, signature=0, LFSR=SEED (or 1), state IDLE. Reset mid-run discards the run.
- FSM states: IDLE, ZERO, APPLY, DONE.
- IDLE or DONE with start=1 at cycle t:
  - clears the results, LFSR, vec_idx and the hold counter;
  - enters ZERO at t+1.
- start while busy is ignored.
- ZERO drives stim=0 for HOLD cycles (vec_idx=0), then enters APPLY.
- APPLY:
  - vector k (1..NUM_VEC) is driven during cycles t+1+k*HOLD .. t+(k+1)*HOLD;
  - vector 1 stim = low IN_W bits of SEED;
  - each subsequent vector advances the LFSR once.
- LFSR: 64-bit Galois, next = (s>>1) ^ (s[0] ? 64'hD800000000000000 : 0).
- Compare occurs only on the last cycle of each hold window (including the zero vector), sampling y_ref and y_dut.
  - On inequality: mismatch<=1; fail_count increments, saturating at all-ones.
  - If this is the first failure, first_fail_idx<=vec_idx.
- MISR update on the same sample cycle:
  - fold = XOR of y_dut split into 32-bit words, last word zero-padded;
  - sig <= {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.
- After the vector NUM_VEC compare, enter DONE on the next cycle:
  - done=1, busy=0, stim holds its last value;
  - results are stable until the next start.
- abort in ZERO/APPLY: next state IDLE, stim=0, busy=0, done=0; partial results are retained.
- abort and start in the same cycle: abort wins.

Decomposition:
- Shared package fuzz_harness_pkg holds:
  - LFSR_POLY, MISR_POLY;
  - the state enum;
  - a fold function.
- One sub-module, fuzz_misr32, contains the fold and MISR register; it has enable and clear inputs.

Test Plan:
1. IN_W=64, NUM_VEC=3, HOLD=1, SEED=1, y_ref=y_dut: start at t.
   - stim = 0, 64'h1, 64'hD800000000000000, 64'h6C00000000000000 on t+1..t+4.
   - done at t+5; mismatch=0, fail_count=0.
2. Same setup, y_dut bit0 flipped during vector 2 only.
   - Requires mismatch=1, first_fail_idx=2, fail_count=1.
3. OUT_W=32, NUM_VEC=3, y_dut=32'h1 constant.
   - signature goes 1, 3, 7, 8'hF after the four samples.
   - With y_dut=0 the signature stays 0.
4. HOLD=3, y_dut differs from y_ref on the first two cycles of every window but matches on the third.
   - Requires mismatch=0; each stim value stable for exactly 3 cycles.
5. COUNT_W=2, NUM_VEC=5, y_dut always differs.
   - Requires fail_count=3 (saturated), first_fail_idx=0.
6. rst_n low during vector 2, then start again; separately, abort during APPLY.
   - After reset: all outputs at reset values; the rerun repeats the test-1 stim sequence.
   - After abort: IDLE next cycle, done=0.
   - start pulsed while busy: no effect.
